// File: rtl/difftest_dma_pkg.sv
// rtl/difftest_dma_pkg.sv - shared widths and serializer state for the difftest DMA packer
package difftest_dma_pkg;
  localparam int FRAME_W = 4064;
  localparam int BEAT_W  = 512;
  localparam int HDR_W   = 32;
  localparam int BEATS   = 8;
  localparam int IDX_W   = 3;
  localparam int WORD_W  = FRAME_W + HDR_W;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;
endpackage

// File: rtl/difftest_frame_buf.sv
// rtl/difftest_frame_buf.sv - two-entry frame FIFO holding {hdr, payload} words
module difftest_frame_buf
  import difftest_dma_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [WORD_W-1:0] head
);
  logic [WORD_W-1:0] mem_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  // push while full is only issued together with pop, so the freed slot is reused
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // payload storage carries no reset; emptiness is tracked by count_q alone
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/difftest_dma_packer.sv
// rtl/difftest_dma_packer.sv - buffers difftest frames and emits them as 8-beat streams
// Optional DIFFTEST_DMA_SEQ_EN places a wrapping sequence number in the frame header.
module difftest_dma_packer #(
  parameter int FRAME_W = 4064,
  parameter int BEAT_W  = 512,
  parameter int DEPTH   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [FRAME_W-1:0]  in_data,
  input  logic                in_enable,
  output logic [BEAT_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [BEAT_W/8-1:0] m_axis_tkeep,
  output logic [31:0]         drop_count,
  output logic                busy
);
  import difftest_dma_pkg::*;

  localparam int COUNT_W = $clog2(DEPTH + 1);

  ser_state_e                     state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           tvalid_q, tvalid_d;
  logic                           tlast_q, tlast_d;
  logic                           busy_q, busy_d;
  logic [31:0]                    drop_count_q, drop_count_d;
  logic [COUNT_W-1:0]             count, count_nxt;
  logic [WORD_W-1:0]              head, push_word;
  logic [BEATS-1:0][BEAT_W-1:0]   head_beats;
  logic [HDR_W-1:0]               hdr;
  logic                           hs, pop, push, drop;

`ifdef DIFFTEST_DMA_SEQ_EN
  logic [HDR_W-1:0] seq_q, seq_d;

  // every strobe advances seq, including strobes whose frame is dropped
  always_comb seq_d = seq_q + HDR_W'(in_enable);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) seq_q <= '0;
    else       seq_q <= seq_d;
  end

  assign hdr = seq_q;
`else
  assign hdr = '0;
`endif

  always_comb begin
    hs        = tvalid_q && m_axis_tready;
    pop       = hs && (idx_q == IDX_W'(BEATS - 1));
    push      = in_enable && ((count != COUNT_W'(DEPTH)) || pop);
    drop      = in_enable && !push;
    count_nxt = count + COUNT_W'(push) - COUNT_W'(pop);
    push_word = {hdr, in_data};
  end

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 32'hFFFF_FFFF)) drop_count_d = drop_count_q + 32'd1;
  end

  // next-state looks at the post-push/pop occupancy so beats continue without bubbles
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (count_nxt != '0) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (hs) begin
          if (pop) begin
            idx_d   = '0;
            state_d = (count_nxt != '0) ? SEND : IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    tvalid_d = (state_d == SEND);
    tlast_d  = tvalid_d && (idx_d == IDX_W'(BEATS - 1));
    busy_d   = (count_nxt != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      busy_q       <= busy_d;
      drop_count_q <= drop_count_d;
    end
  end

  difftest_frame_buf u_frame_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  // head only changes on the final handshake, so tdata holds through stalls
  assign head_beats    = head;
  assign m_axis_tdata  = tvalid_q ? head_beats[idx_q] : '0;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tkeep  = {(BEAT_W/8){tvalid_q}};
  assign drop_count    = drop_count_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_difftest_dma_packer.sv
// tb/tb_difftest_dma_packer.sv - self-checking bench for difftest_dma_packer
module tb_difftest_dma_packer;
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [4063:0] in_data = '0;
  logic          in_enable = 1'b0;
  logic          tready = 1'b0;
  logic [511:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic [63:0]   m_axis_tkeep;
  logic [31:0]   drop_count;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int dut_hs = 0;

  logic [4095:0] mq[$];
  int            m_beat = 0;
  logic [31:0]   m_drop = '0;
  logic [31:0]   m_seq = '0;

  typedef struct {
    bit          en;
    bit          rdy;
    int          id;
    bit          v;
    bit          last;
    bit          bsy;
    logic [31:0] drop;
    int          eid;
    int          ebeat;
    logic [31:0] eseq;
  } vec_t;
  vec_t vt[$];

  difftest_dma_packer dut (
    .clock         (clock),
    .reset         (reset),
    .in_data       (in_data),
    .in_enable     (in_enable),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] hdr_of(input logic [31:0] s);
    logic [31:0] mask;
`ifdef DIFFTEST_DMA_SEQ_EN
    mask = 32'hFFFF_FFFF;
`else
    mask = 32'h0;
`endif
    return s & mask;
  endfunction

  function automatic logic [4063:0] pattern(input int id);
    logic [4063:0] f;
    for (int i = 0; i < 508; i++) f[8*i +: 8] = 8'(i + 3 * id);
    return f;
  endfunction

  function automatic logic [4063:0] rand_frame();
    logic [4063:0] f;
    for (int i = 0; i < 127; i++) f[32*i +: 32] = $urandom;
    return f;
  endfunction

  function automatic void add(input bit en, input bit rdy, input int id, input bit v,
                              input bit last, input bit bsy, input logic [31:0] drop,
                              input int eid, input int ebeat, input logic [31:0] eseq);
    vec_t r;
    r.en = en; r.rdy = rdy; r.id = id; r.v = v; r.last = last; r.bsy = bsy;
    r.drop = drop; r.eid = eid; r.ebeat = ebeat; r.eseq = eseq;
    vt.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    if (mq.size() != 0 && tready) begin
      if (m_beat == 7) begin
        m_beat = 0;
        void'(mq.pop_front());
      end else begin
        m_beat++;
      end
    end
    if (in_enable) begin
      if (mq.size() < 2) mq.push_back({hdr_of(m_seq), in_data});
      else if (m_drop != 32'hFFFF_FFFF) m_drop++;
      m_seq++;
    end
  endtask

  task automatic check_model();
    logic [4095:0] w;
    bit v;
    v = (mq.size() != 0);
    chk("tvalid", m_axis_tvalid, v);
    chk("busy", busy, v);
    chk("drop_count", drop_count, m_drop);
    chk("tkeep", m_axis_tkeep, v ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
    if (v) begin
      w = mq[0];
      chk("tdata", m_axis_tdata, w[512*m_beat +: 512]);
      chk("tlast", m_axis_tlast, m_beat == 7);
    end
  endtask

  task automatic cycle(input bit en, input bit rdy, input logic [4063:0] d);
    in_enable = en;
    tready = rdy;
    in_data = d;
    if (m_axis_tvalid && rdy) begin
      dut_hs++;
      if (m_axis_tlast) begin
        chk("beats_per_frame", dut_hs, 8);
        dut_hs = 0;
      end
    end
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_enable = 1'b0;
    tready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    mq.delete();
    m_beat = 0;
    m_drop = '0;
    m_seq = '0;
    dut_hs = 0;
  endtask

  initial begin
    logic [4095:0] w;

    // single frame with sink ready, then three back-to-back strobes into a stalled sink
    add(1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k < 8; k++) add(0, 1, 0, 1, k == 7, 1, 0, 0, k, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 1, 0, 1, 0, 1);
    add(1, 0, 2, 1, 0, 1, 0, 1, 0, 1);
    add(1, 0, 3, 1, 0, 1, 1, 1, 0, 1);
    for (int k = 0; k < 16; k++) begin
      if (k < 15) add(0, 1, 0, 1, ((k + 1) % 8) == 7, 1, 1, 1 + (k + 1) / 8, (k + 1) % 8, 1 + (k + 1) / 8);
      else        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    end

    do_reset();
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tkeep", m_axis_tkeep, 64'h0);
    chk("rst_tdata", m_axis_tdata, 512'h0);
    chk("rst_drop", drop_count, 32'h0);
    chk("rst_busy", busy, 1'b0);

    for (int i = 0; i < vt.size(); i++) begin
      in_enable = vt[i].en;
      tready = vt[i].rdy;
      in_data = pattern(vt[i].id);
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("vec%0d_tvalid", i), m_axis_tvalid, vt[i].v);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].bsy);
      chk($sformatf("vec%0d_drop", i), drop_count, vt[i].drop);
      if (vt[i].v) begin
        w = {hdr_of(vt[i].eseq), pattern(vt[i].eid)};
        chk($sformatf("vec%0d_tlast", i), m_axis_tlast, vt[i].last);
        chk($sformatf("vec%0d_tdata", i), m_axis_tdata, w[512*vt[i].ebeat +: 512]);
      end
    end

    // ready toggling every cycle
    do_reset();
    cycle(1, 0, pattern(7));
    for (int i = 0; i < 18; i++) cycle(0, (i % 2) == 0, '0);

    // full buffer: new strobe coincides with the final handshake of the head frame
    do_reset();
    cycle(1, 0, pattern(10));
    cycle(1, 0, pattern(11));
    for (int i = 0; i < 7; i++) cycle(0, 1, '0);
    cycle(1, 1, pattern(12));
    chk("coincide_drop", drop_count, 32'h0);
    for (int i = 0; i < 17; i++) cycle(0, 1, '0);

    // reset in the middle of a frame with another frame buffered
    do_reset();
    cycle(1, 0, pattern(20));
    cycle(1, 0, pattern(21));
    cycle(1, 0, pattern(22));
    for (int i = 0; i < 4; i++) cycle(0, 1, '0);
    reset = 1'b1;
    #1;
    chk("async_rst_tvalid", m_axis_tvalid, 1'b0);
    chk("async_rst_tkeep", m_axis_tkeep, 64'h0);
    do_reset();
    for (int i = 0; i < 10; i++) cycle(0, 1, '0);

    // drop counter saturation
    force dut.drop_count_d = 32'hFFFF_FFFE;
    @(posedge clock);
    @(negedge clock);
    release dut.drop_count_d;
    m_drop = 32'hFFFF_FFFE;
    for (int i = 0; i < 5; i++) cycle(1, 0, pattern(30 + i));
    chk("sat_drop", drop_count, 32'hFFFF_FFFF);
    for (int i = 0; i < 17; i++) cycle(0, 1, '0);

    // random traffic against the queue model
    do_reset();
    for (int i = 0; i < 800; i++) cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, rand_frame());
    for (int i = 0; i < 20; i++) cycle(0, 1, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
